cache_control: RTL



---
 rtl/cache_ctrl_pkg.sv | 18 +
 rtl/cache_ctrl_perf.sv | 35 +++
 rtl/cache_control.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and encodings for the L1 cache controller.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  localparam logic [1:0] PMEM_SEL_CPU  = 2'b00;
  localparam logic [1:0] PMEM_SEL_WAY1 = 2'b01;
  localparam logic [1:0] PMEM_SEL_WAY2 = 2'b10;

  localparam logic WAY1 = 1'b0;
  localparam logic WAY2 = 1'b1;

endpackage

// File: rtl/cache_ctrl_perf.sv
// Hit / miss / writeback event counters for the cache controller.
// Only instantiated when CACHE_CTRL_PERF_EN is defined; counters wrap at 2^32.
module cache_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hit,
  input  logic        i_miss,
  input  logic        i_wb,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count,
  output logic [31:0] o_wb_count
);

  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic [31:0] r_wb_count;

  // Count one event per cycle on each pulse input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_wb_count   <= '0;
    end else begin
      if (i_hit)  r_hit_count  <= r_hit_count + 32'd1;
      if (i_miss) r_miss_count <= r_miss_count + 32'd1;
      if (i_wb)   r_wb_count   <= r_wb_count + 32'd1;
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
  assign o_wb_count   = r_wb_count;

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way set-associative, write-back, write-allocate L1.
// Resolves hits, picks the LRU victim, writes back dirty lines, refills.
// Optional performance counters: define CACHE_CTRL_PERF_EN.
module cache_control
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned s_mask = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [s_mask-1:0] mem_byte_enable256,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp,
  input  logic              hit1,
  input  logic              hit2,
  input  logic              valid1,
  input  logic              valid2,
  input  logic              dirty1,
  input  logic              dirty2,
  input  logic              lru_out,
  output logic              data_r1,
  output logic              data_r2,
  output logic              read_tag1,
  output logic              read_tag2,
  output logic              read_valid1,
  output logic              read_valid2,
  output logic              read_dirty1,
  output logic              read_dirty2,
  output logic [s_mask-1:0] data_w1,
  output logic [s_mask-1:0] data_w2,
  output logic              load_tag1,
  output logic              load_tag2,
  output logic              load_valid1,
  output logic              load_valid2,
  output logic              load_dirty1,
  output logic              load_dirty2,
  output logic              load_lru,
  output logic              valid_in,
  output logic              dirty_in,
  output logic              lru_in,
  output logic              data_sel,
  output logic              path_sel,
  output logic [1:0]        pmem_sel,
  output logic              load_pmem_wdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
);

  state_t r_state;
  state_t w_next_state;
  logic   r_victim;

  logic w_req;
  logic w_hit1;
  logic w_hit2;
  logic w_hit;
  logic w_hit_way;
  logic w_victim_dirty;

  assign w_req          = mem_read | mem_write;
  assign w_hit1         = hit1 & valid1;
  assign w_hit2         = hit2 & valid2;
  assign w_hit          = w_hit1 | w_hit2;
  // Way 1 takes priority when both ways report a hit.
  assign w_hit_way      = w_hit1 ? WAY1 : WAY2;
  assign w_victim_dirty = (lru_out == WAY2) ? (valid2 & dirty2) : (valid1 & dirty1);

  // State register and victim latch captured on a CHECK miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_victim <= WAY1;
    end else begin
      r_state <= w_next_state;
      if (r_state == CHECK && w_req && !w_hit) begin
        r_victim <= lru_out;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) w_next_state = CHECK;
      end
      CHECK: begin
        if (!w_req || w_hit)  w_next_state = IDLE;
        else if (w_victim_dirty) w_next_state = WRITEBACK;
        else                  w_next_state = ALLOCATE;
      end
      WRITEBACK: begin
        if (pmem_resp) w_next_state = ALLOCATE;
      end
      ALLOCATE: begin
        if (pmem_resp) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath control decode.
  always_comb begin
    data_r1         = 1'b1;
    data_r2         = 1'b1;
    read_tag1       = 1'b1;
    read_tag2       = 1'b1;
    read_valid1     = 1'b1;
    read_valid2     = 1'b1;
    read_dirty1     = 1'b1;
    read_dirty2     = 1'b1;
    data_w1         = '0;
    data_w2         = '0;
    load_tag1       = 1'b0;
    load_tag2       = 1'b0;
    load_valid1     = 1'b0;
    load_valid2     = 1'b0;
    load_dirty1     = 1'b0;
    load_dirty2     = 1'b0;
    load_lru        = 1'b0;
    valid_in        = 1'b0;
    dirty_in        = 1'b0;
    lru_in          = 1'b0;
    data_sel        = 1'b0;
    path_sel        = 1'b0;
    pmem_sel        = PMEM_SEL_CPU;
    load_pmem_wdata = 1'b0;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;

    case (r_state)
      CHECK: begin
        if (w_req && w_hit) begin
          path_sel = w_hit_way;
          mem_resp = 1'b1;
          load_lru = 1'b1;
          lru_in   = ~w_hit_way;
          if (mem_write) begin
            data_sel = 1'b1;
            dirty_in = 1'b1;
            if (w_hit_way == WAY1) begin
              data_w1     = mem_byte_enable256;
              load_dirty1 = 1'b1;
            end else begin
              data_w2     = mem_byte_enable256;
              load_dirty2 = 1'b1;
            end
          end
        end else if (w_req && w_victim_dirty) begin
          path_sel        = lru_out;
          load_pmem_wdata = 1'b1;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_sel   = (r_victim == WAY2) ? PMEM_SEL_WAY2 : PMEM_SEL_WAY1;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        pmem_sel  = PMEM_SEL_CPU;
        if (pmem_resp) begin
          data_sel = 1'b0;
          valid_in = 1'b1;
          dirty_in = 1'b0;
          if (r_victim == WAY1) begin
            data_w1     = '1;
            load_tag1   = 1'b1;
            load_valid1 = 1'b1;
            load_dirty1 = 1'b1;
          end else begin
            data_w2     = '1;
            load_tag2   = 1'b1;
            load_valid2 = 1'b1;
            load_dirty2 = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_PERF_EN
  logic w_hit_evt;
  logic w_miss_evt;
  logic w_wb_evt;

  assign w_hit_evt  = (r_state == CHECK) && w_req && w_hit;
  assign w_miss_evt = (r_state == CHECK) && w_req && !w_hit;
  assign w_wb_evt   = (r_state == WRITEBACK) && pmem_resp;

  cache_ctrl_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .i_hit        (w_hit_evt),
    .i_miss       (w_miss_evt),
    .i_wb         (w_wb_evt),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count),
    .o_wb_count   (wb_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule
